// File: rtl/cr_tlvp_gen.sv
// cr_tlvp_gen: TLV frame generator.
// Builds header + payload (+ optional XOR trailer) words from a command and a
// payload stream and queues them in an internal FIFO that is drained through
// the empty/aempty/rd handshake.
// Optional feature macro: CR_TLVP_GEN_TRAILER_EN (adds the XOR trailer word).
module cr_tlvp_gen #(
  parameter int N_OF_ENTRIES    = 16,
  parameter int N_OF_AEMPTY_VAL = 1,
  parameter int MAX_LEN         = 254
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  module_id,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_typ,
  input  logic [7:0]  cmd_len,
  input  logic        pld_valid,
  output logic        pld_ready,
  input  logic [63:0] pld_data,
  input  logic        tlvp_ob_rd,
  output logic        tlvp_ob_empty,
  output logic        tlvp_ob_aempty,
  output logic [63:0] tlvp_ob_tdata,
  output logic        tlvp_ob_sot,
  output logic        tlvp_ob_tlast,
  output logic        tlvp_gen_error
);

  localparam int AW = $clog2(N_OF_ENTRIES);
  localparam logic [AW:0] FULL_CNT   = (AW+1)'(N_OF_ENTRIES);
  localparam logic [AW:0] AEMPTY_CNT = (AW+1)'(N_OF_AEMPTY_VAL);
`ifdef CR_TLVP_GEN_TRAILER_EN
  localparam logic [15:0] HDR_EXTRA = 16'd2;
`else
  localparam logic [15:0] HDR_EXTRA = 16'd1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PLD,
    ST_TRL
  } state_t;

  state_t      state;
  logic [7:0]  typ_q;
  logic [7:0]  len_q;
  logic [7:0]  remaining;
  logic [15:0] seq;
  logic        error_q;
`ifdef CR_TLVP_GEN_TRAILER_EN
  logic [63:0] acc;
`endif

  // Output FIFO storage: {sot, tlast, data}
  logic [65:0]   mem [N_OF_ENTRIES];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic        fifo_full;
  logic        pop;
  logic        wr_en;
  logic [63:0] wr_data;
  logic        wr_sot;
  logic        wr_tlast;
  logic        pld_accept;
  logic [15:0] hdr_total;
  logic [63:0] hdr_word;
  logic [65:0] head;

  assign fifo_full  = (count == FULL_CNT);
  assign pop        = tlvp_ob_rd && (count != '0);
  assign pld_accept = (state == ST_PLD) && !fifo_full && pld_valid;
  assign hdr_total  = {8'h00, len_q} + HDR_EXTRA;
  assign hdr_word   = {16'h0000, seq, module_id, hdr_total, typ_q};

  assign cmd_ready      = rst_n && (state == ST_IDLE);
  assign pld_ready      = (state == ST_PLD) && !fifo_full;
  assign head           = mem[rd_ptr];
  assign tlvp_ob_tdata  = head[63:0];
  assign tlvp_ob_tlast  = head[64];
  assign tlvp_ob_sot    = head[65];
  assign tlvp_ob_empty  = (count == '0);
  assign tlvp_ob_aempty = (count <= AEMPTY_CNT);
  assign tlvp_gen_error = error_q;

  // Select the word (if any) the FSM pushes into the FIFO this cycle
  always_comb begin
    wr_en    = 1'b0;
    wr_data  = '0;
    wr_sot   = 1'b0;
    wr_tlast = 1'b0;
    case (state)
      ST_HDR: if (!fifo_full) begin
        wr_en   = 1'b1;
        wr_data = hdr_word;
        wr_sot  = 1'b1;
`ifdef CR_TLVP_GEN_TRAILER_EN
        wr_tlast = 1'b0;
`else
        wr_tlast = (len_q == 8'd0);
`endif
      end
      ST_PLD: if (pld_accept) begin
        wr_en   = 1'b1;
        wr_data = pld_data;
`ifdef CR_TLVP_GEN_TRAILER_EN
        wr_tlast = 1'b0;
`else
        wr_tlast = (remaining == 8'd1);
`endif
      end
`ifdef CR_TLVP_GEN_TRAILER_EN
      ST_TRL: if (!fifo_full) begin
        wr_en    = 1'b1;
        wr_data  = acc;
        wr_tlast = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Frame-building FSM, sequence number and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      typ_q     <= '0;
      len_q     <= '0;
      remaining <= '0;
      seq       <= '0;
      error_q   <= 1'b0;
`ifdef CR_TLVP_GEN_TRAILER_EN
      acc       <= '0;
`endif
    end else begin
      if (tlvp_ob_rd && (count == '0)) begin
        error_q <= 1'b1;
      end
      case (state)
        ST_IDLE: if (cmd_valid) begin
          if (32'(cmd_len) > MAX_LEN) begin
            error_q <= 1'b1;
          end else begin
            typ_q     <= cmd_typ;
            len_q     <= cmd_len;
            remaining <= cmd_len;
            state     <= ST_HDR;
          end
        end
        ST_HDR: if (!fifo_full) begin
          seq <= seq + 16'd1;
`ifdef CR_TLVP_GEN_TRAILER_EN
          acc   <= '0;
          state <= (len_q == 8'd0) ? ST_TRL : ST_PLD;
`else
          state <= (len_q == 8'd0) ? ST_IDLE : ST_PLD;
`endif
        end
        ST_PLD: if (pld_accept) begin
          remaining <= remaining - 8'd1;
`ifdef CR_TLVP_GEN_TRAILER_EN
          acc <= acc ^ pld_data;
          if (remaining == 8'd1) state <= ST_TRL;
`else
          if (remaining == 8'd1) state <= ST_IDLE;
`endif
        end
`ifdef CR_TLVP_GEN_TRAILER_EN
        ST_TRL: if (!fifo_full) begin
          state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output FIFO: write/pop pointers, occupancy and storage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < N_OF_ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {wr_sot, wr_tlast, wr_data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_cr_tlvp_gen.sv
// Self-checking bench for cr_tlvp_gen: a cycle table for the basic frames,
// then directed sequences for FIFO full, errors and reset mid-frame.
// Honours CR_TLVP_GEN_TRAILER_EN to pick the matching expectations.
module tb_cr_tlvp_gen;

`ifdef CR_TLVP_GEN_TRAILER_EN
  localparam int TRL_W = 1;
`else
  localparam int TRL_W = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  module_id = 8'h05;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_typ;
  logic [7:0]  cmd_len;
  logic        pld_valid;
  logic        pld_ready;
  logic [63:0] pld_data;
  logic        tlvp_ob_rd;
  logic        tlvp_ob_empty;
  logic        tlvp_ob_aempty;
  logic [63:0] tlvp_ob_tdata;
  logic        tlvp_ob_sot;
  logic        tlvp_ob_tlast;
  logic        tlvp_gen_error;

  int checks = 0;
  int errors = 0;

  cr_tlvp_gen #(.N_OF_ENTRIES(16), .N_OF_AEMPTY_VAL(1), .MAX_LEN(254)) dut (
    .clk(clk), .rst_n(rst_n), .module_id(module_id),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_typ(cmd_typ), .cmd_len(cmd_len),
    .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
    .tlvp_ob_rd(tlvp_ob_rd), .tlvp_ob_empty(tlvp_ob_empty), .tlvp_ob_aempty(tlvp_ob_aempty),
    .tlvp_ob_tdata(tlvp_ob_tdata), .tlvp_ob_sot(tlvp_ob_sot), .tlvp_ob_tlast(tlvp_ob_tlast),
    .tlvp_gen_error(tlvp_gen_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        cmd_valid;
    bit [7:0]  cmd_typ;
    bit [7:0]  cmd_len;
    bit        pld_valid;
    bit [63:0] pld_data;
    bit        rd;
    bit        exp_cmd_ready;
    bit        exp_pld_ready;
    bit        exp_empty;
    bit        exp_aempty;
    bit        exp_error;
    bit        chk_head;
    bit [63:0] exp_tdata;
    bit        exp_sot;
    bit        exp_tlast;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit cv, bit [7:0] typ, bit [7:0] len, bit pv, bit [63:0] pd,
                              bit rd, bit ecr, bit epr, bit ee, bit chk, bit [63:0] etd,
                              bit esot, bit etl);
    vec_t v;
    v.cmd_valid = cv; v.cmd_typ = typ; v.cmd_len = len;
    v.pld_valid = pv; v.pld_data = pd; v.rd = rd;
    v.exp_cmd_ready = ecr; v.exp_pld_ready = epr; v.exp_empty = ee;
    v.exp_aempty = 1'b1; v.exp_error = 1'b0;
    v.chk_head = chk; v.exp_tdata = etd; v.exp_sot = esot; v.exp_tlast = etl;
    return v;
  endfunction

  function automatic logic [63:0] pw(int k);
    return 64'hA5A5_0000_0000_0000 + 64'(k);
  endfunction

  function automatic logic [63:0] hdrWord(logic [7:0] typ, int len, logic [15:0] sq);
    logic [15:0] total;
    total = 16'(len + 1 + TRL_W);
    return {16'h0000, sq, 8'h05, total, typ};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    cmd_valid  = v.cmd_valid;
    cmd_typ    = v.cmd_typ;
    cmd_len    = v.cmd_len;
    pld_valid  = v.pld_valid;
    pld_data   = v.pld_data;
    tlvp_ob_rd = v.rd;
  endtask

  task automatic idleInputs();
    cmd_valid = 0; cmd_typ = 0; cmd_len = 0;
    pld_valid = 0; pld_data = 0; tlvp_ob_rd = 0;
  endtask

  // Hold reset across one edge and check every reset output value
  task automatic resetPulse(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    idleInputs();
    @(negedge clk);
    checkOutput({tag, " rst cmd_ready"}, cmd_ready, 0);
    checkOutput({tag, " rst pld_ready"}, pld_ready, 0);
    checkOutput({tag, " rst empty"}, tlvp_ob_empty, 1);
    checkOutput({tag, " rst aempty"}, tlvp_ob_aempty, 1);
    checkOutput({tag, " rst tdata"}, tlvp_ob_tdata, 0);
    checkOutput({tag, " rst sot"}, tlvp_ob_sot, 0);
    checkOutput({tag, " rst tlast"}, tlvp_ob_tlast, 0);
    checkOutput({tag, " rst error"}, tlvp_gen_error, 0);
    rst_n = 1'b1;
  endtask

  // Send one command, stream its payload and drain the FIFO, checking every word
  task automatic sendAndDrain(input string tag, input logic [7:0] typ, input int len,
                              input logic [15:0] sq);
    logic [63:0] exp[$];
    logic [63:0] acc;
    int sent;
    int idx;
    int guard;
    acc = '0;
    exp.push_back(hdrWord(typ, len, sq));
    for (int k = 1; k <= len; k++) begin
      exp.push_back(pw(k));
      acc ^= pw(k);
    end
    if (TRL_W == 1) exp.push_back(acc);
    @(negedge clk);
    cmd_valid = 1; cmd_typ = typ; cmd_len = 8'(len);
    @(negedge clk);
    cmd_valid = 0;
    sent = 0; idx = 0; guard = 0;
    while (idx < exp.size() && guard < 200) begin
      if (sent < len) begin
        pld_valid = 1; pld_data = pw(sent + 1);
        if (pld_ready) sent++;
      end else begin
        pld_valid = 0;
      end
      tlvp_ob_rd = !tlvp_ob_empty;
      if (!tlvp_ob_empty) begin
        checkOutput($sformatf("%s word%0d data", tag, idx), tlvp_ob_tdata, exp[idx]);
        checkOutput($sformatf("%s word%0d sot", tag, idx), tlvp_ob_sot, idx == 0);
        checkOutput($sformatf("%s word%0d tlast", tag, idx), tlvp_ob_tlast,
                    idx == exp.size() - 1);
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    tlvp_ob_rd = 0; pld_valid = 0;
    checkOutput({tag, " words drained"}, 64'(idx), 64'(exp.size()));
    checkOutput({tag, " empty after"}, tlvp_ob_empty, 1);
    checkOutput({tag, " error after"}, tlvp_gen_error, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [63:0] fexp[$];
    logic [63:0] facc;
    int sent;
    int idx;
    int guard;
    rst_n = 1'b0;
    idleInputs();
    @(negedge clk);
    resetPulse("init");

    // Cycle table: frame typ 0x21 len 2, then a len 0 frame (seq 1)
    vecs.push_back(mk(1, 8'h21, 2, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 64'h1111_1111_1111_1111, 0,  0, 0, 1, 0, 0, 0, 0));
`ifdef CR_TLVP_GEN_TRAILER_EN
    vecs.push_back(mk(0, 0, 0, 1, 64'h1111_1111_1111_1111, 1,  0, 1, 0, 1, 64'h0000_0000_0500_0421, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 64'h2222_2222_2222_2222, 1,  0, 1, 0, 1, 64'h1111_1111_1111_1111, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 64'h2222_2222_2222_2222, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 64'h3333_3333_3333_3333, 0, 1));
    vecs.push_back(mk(1, 8'h22, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 64'h0000_0001_0500_0222, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 64'h0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0));
`else
    vecs.push_back(mk(0, 0, 0, 1, 64'h1111_1111_1111_1111, 1,  0, 1, 0, 1, 64'h0000_0000_0500_0321, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 64'h2222_2222_2222_2222, 1,  0, 1, 0, 1, 64'h1111_1111_1111_1111, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 64'h2222_2222_2222_2222, 0, 1));
    vecs.push_back(mk(1, 8'h22, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 64'h0000_0001_0500_0122, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0));
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      checkOutput($sformatf("row%0d cmd_ready", i), cmd_ready, vecs[i].exp_cmd_ready);
      checkOutput($sformatf("row%0d pld_ready", i), pld_ready, vecs[i].exp_pld_ready);
      checkOutput($sformatf("row%0d empty", i), tlvp_ob_empty, vecs[i].exp_empty);
      checkOutput($sformatf("row%0d aempty", i), tlvp_ob_aempty, vecs[i].exp_aempty);
      checkOutput($sformatf("row%0d error", i), tlvp_gen_error, vecs[i].exp_error);
      if (vecs[i].chk_head) begin
        checkOutput($sformatf("row%0d tdata", i), tlvp_ob_tdata, vecs[i].exp_tdata);
        checkOutput($sformatf("row%0d sot", i), tlvp_ob_sot, vecs[i].exp_sot);
        checkOutput($sformatf("row%0d tlast", i), tlvp_ob_tlast, vecs[i].exp_tlast);
      end
      applyStimulus(vecs[i]);
    end

    // FIFO full: len 20 with no reads, one pop, then drain in order (seq 2)
    facc = '0;
    fexp.push_back(hdrWord(8'h30, 20, 16'd2));
    for (int k = 1; k <= 20; k++) begin
      fexp.push_back(pw(k));
      facc ^= pw(k);
    end
    if (TRL_W == 1) fexp.push_back(facc);
    @(negedge clk);
    idleInputs();
    cmd_valid = 1; cmd_typ = 8'h30; cmd_len = 8'd20;
    @(negedge clk);
    cmd_valid = 0;
    sent = 0;
    repeat (30) begin
      pld_valid = 1; pld_data = pw(sent + 1);
      if (pld_ready) sent++;
      @(negedge clk);
    end
    checkOutput("full accepted words", 64'(sent), 15);
    checkOutput("full pld_ready", pld_ready, 0);
    checkOutput("full empty", tlvp_ob_empty, 0);
    checkOutput("full aempty", tlvp_ob_aempty, 0);
    checkOutput("full head header", tlvp_ob_tdata, fexp[0]);
    pld_data = pw(sent + 1);
    tlvp_ob_rd = 1;
    @(negedge clk);
    tlvp_ob_rd = 0;
    checkOutput("after pop pld_ready", pld_ready, 1);
    pld_data = pw(sent + 1);
    if (pld_ready) sent++;
    @(negedge clk);
    checkOutput("refill pld_ready", pld_ready, 0);
    checkOutput("refill head", tlvp_ob_tdata, fexp[1]);
    checkOutput("refill accepted words", 64'(sent), 16);
    pld_data = pw(sent + 1);
    tlvp_ob_rd = 1;
    idx = 2; guard = 0;
    while (idx < fexp.size() && guard < 200) begin
      @(negedge clk);
      guard++;
      if (sent < 20) begin
        pld_valid = 1; pld_data = pw(sent + 1);
        if (pld_ready) sent++;
      end else begin
        pld_valid = 0;
      end
      tlvp_ob_rd = !tlvp_ob_empty;
      if (!tlvp_ob_empty) begin
        checkOutput($sformatf("full word%0d data", idx), tlvp_ob_tdata, fexp[idx]);
        checkOutput($sformatf("full word%0d tlast", idx), tlvp_ob_tlast, idx == fexp.size() - 1);
        idx++;
      end
    end
    @(negedge clk);
    tlvp_ob_rd = 0; pld_valid = 0;
    checkOutput("full words drained", 64'(idx), 64'(fexp.size()));
    checkOutput("full empty after", tlvp_ob_empty, 1);
    checkOutput("full error after", tlvp_gen_error, 0);

    // Another ordinary frame continues the sequence number
    sendAndDrain("frame31", 8'h31, 3, 16'd3);

    // Oversized command: consumed, no write, sticky error
    @(negedge clk);
    cmd_valid = 1; cmd_typ = 8'h50; cmd_len = 8'd255;
    checkOutput("badlen cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
    checkOutput("badlen error", tlvp_gen_error, 1);
    checkOutput("badlen cmd_ready next", cmd_ready, 1);
    repeat (3) @(negedge clk);
    checkOutput("badlen no write", tlvp_ob_empty, 1);
    checkOutput("badlen error sticky", tlvp_gen_error, 1);
    resetPulse("badlen");

    // Pop on an empty FIFO sets the error and leaves the count at zero
    tlvp_ob_rd = 1;
    @(negedge clk);
    tlvp_ob_rd = 0;
    checkOutput("rdempty error", tlvp_gen_error, 1);
    checkOutput("rdempty empty", tlvp_ob_empty, 1);
    checkOutput("rdempty aempty", tlvp_ob_aempty, 1);
    resetPulse("rdempty");

    // Reset in the middle of a len 5 payload, then a clean frame with seq 0
    @(negedge clk);
    cmd_valid = 1; cmd_typ = 8'h60; cmd_len = 8'd5;
    @(negedge clk);
    cmd_valid = 0;
    pld_valid = 1; pld_data = pw(1);
    repeat (3) @(negedge clk);
    checkOutput("midreset fifo filled", tlvp_ob_empty, 0);
    resetPulse("midreset");
    sendAndDrain("postreset", 8'h44, 1, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cr_tlvp_gen.md
Name: cr_tlvp_gen

Overview:
- TLV generator: the transmit-side counterpart to the TLV parser.
- Builds complete TLV frames from a command (type and length) plus a payload word stream.
- Emits frames as 64-bit data-path words into an internal output FIFO, drained by the downstream stage through the codebase's empty/aempty/rd FIFO handshake.
- Sits at the egress of an engine, in front of the TLV parser input of the next block.

Parameters:
- N_OF_ENTRIES, 16: output FIFO depth in words, power of 2, >=4.
- N_OF_AEMPTY_VAL, 1: tlvp_ob_aempty asserted when occupancy <= this value.
- MAX_LEN, 254: largest legal cmd_len, in payload words.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- module_id  in  8  static id inserted into header
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_typ  in  8  TLV type
- cmd_len  in  8  payload word count, 0..MAX_LEN
- pld_valid  in  1  payload word present
- pld_ready  out  1  payload word accepted when valid&ready
- pld_data  in  64  payload word
- tlvp_ob_rd  in  1  pop FIFO head
- tlvp_ob_empty  out  1  FIFO empty
- tlvp_ob_aempty  out  1  FIFO almost empty
- tlvp_ob_tdata  out  64  FIFO head data
- tlvp_ob_sot  out  1  head word is first word of a TLV
- tlvp_ob_tlast  out  1  head word is last word of a TLV
- tlvp_gen_error  out  1  sticky error flag

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM=IDLE, FIFO pointers and count=0, seq=0, error=0, parity accumulator=0.
  - Output reset values: cmd_ready=0, pld_ready=0, tlvp_ob_empty=1, tlvp_ob_aempty=1, tdata/sot/tlast=0, tlvp_gen_error=0.
  - Reset mid-frame discards the partial frame and all FIFO contents.
- Handshake outputs: cmd_ready=1 only in IDLE. pld_ready=1 only in PLD while fifo_full=0. Both are combinational from registered state.
- FIFO flags: fifo_full = (count==N_OF_ENTRIES). A write occurs only when fifo_full=0 as registered at the start of the cycle; a same-cycle pop does not unblock a write.
- IDLE: on cmd_valid&cmd_ready, latch typ and len, go to HDR.
  - If cmd_len>MAX_LEN: the command is consumed, no frame is emitted, tlvp_gen_error is set, FSM stays IDLE.
- HDR: when fifo_full=0, write the header word, then go to PLD, or to IDLE when len=0 (trailer disabled).
  - Header layout: [7:0]=typ, [23:8]=total words (len+1, or len+2 with trailer), [31:24]=module_id, [47:32]=seq, [63:48]=0.
  - Header word carries sot=1. tlast=1 only when it is the sole word of the frame.
  - seq increments by 1 after each header write and wraps 0xFFFF->0.
- PLD: each accepted payload word is written to the FIFO the same cycle and a remaining-word counter decrements.
  - The final payload word has tlast=1 (trailer disabled), then FSM goes to IDLE.
  - Payload stalls (pld_valid=0) hold state indefinitely.
- FIFO output: tlvp_ob_tdata/sot/tlast always show the head word; they are valid only when tlvp_ob_empty=0.
  - tlvp_ob_empty deasserts the cycle after the first write (1-cycle write-to-visible latency).
  - tlvp_ob_rd while empty is ignored and sets tlvp_gen_error.
  - Simultaneous write and pop with count in 1..N-1: count is unchanged.
  - Pointers wrap modulo N_OF_ENTRIES.
- tlvp_gen_error is sticky until reset.
- Command-to-first-word latency: cmd accept at cycle T, header written at T+1, tlvp_ob_empty=0 at T+2.

Optional Feature:
- Macro: CR_TLVP_GEN_TRAILER_EN.
- When defined:
  - Adds a TRL state after PLD (or after HDR when len=0).
  - In TRL, when fifo_full=0, writes a trailer word = XOR of all payload words of the frame (0 when len=0), with tlast=1.
  - Payload words then carry tlast=0.
  - Header total-words field = len+2.
  - The accumulator clears when a header is written.
- When undefined: no TRL state, no accumulator, total-words field = len+1.

Test Plan:
- Frame with typ=0x21, len=2, module_id=0x05, payloads 0x1111..., 0x2222..., continuous reads -> three words. Header = 0x0000_0000_0500_0321 (seq 0, 3 words) with sot=1. Last payload word has tlast=1. Next frame header seq=1.
- Trailer build, same frame -> header total=4; trailer = 0x3333_3333_3333_3333 with tlast=1.
- len=0 command -> single header word with sot=1 and tlast=1 (trailer build: header then trailer 0x0).
- tlvp_ob_rd held 0, 20 payload words, N=16 -> writes stop at count=16 and pld_ready=0. A single pop frees one slot; the next write lands one cycle after the pop. Data order is preserved.
- cmd_len=255 -> no FIFO write, tlvp_gen_error=1, cmd_ready=1 again on the next cycle. Separately, tlvp_ob_rd on an empty FIFO -> error set, count stays 0.
- Reset asserted mid-payload of a len=5 frame -> empty=1, error=0, seq=0. The next command produces a clean frame with seq=0.
